// File: rtl/edge_delay_pkg.sv
// -----------------------------------------------------------------------------
// edge_delay_pkg
//   Shared types and helpers for the edge_delay_filter block.
//   - cell_state_t : state of one inertial delay cell (STABLE / PEND)
//   - MAX_DW       : widest delay value the helper function can handle
//   - eff_delay()  : maps a programmed delay to the delay actually counted
//                    (0 is promoted to 1, so there is never a zero-latency path)
// -----------------------------------------------------------------------------
package edge_delay_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_PEND   = 1'b1
   } cell_state_t;

   // Cells may be built with any DW up to this width.
   localparam int unsigned MAX_DW = 32;

   // A programmed delay of 0 still costs one cycle: the cell always registers
   // the input before it can move its output.
   function automatic logic [MAX_DW-1:0] eff_delay(input logic [MAX_DW-1:0] dly);
      return (dly == '0) ? MAX_DW'(1) : dly;
   endfunction

endpackage : edge_delay_pkg

// File: rtl/edge_delay_filter_cell.sv
// -----------------------------------------------------------------------------
// inertial_cell
//   One inertial delay path. The output q follows the input after a delay that
//   depends on the direction of the transition (rdly for 0->1, fdly for 1->0).
//   A pulse that returns before the delay expires is swallowed and reported
//   on cancel for one cycle.
//
// Parameters
//   DW    : width of delay values and of the down-counter (DW <= MAX_DW)
//   RST_Q : reset level of q
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   en     in   advance enable; 0 freezes state and masks cancel
//   in     in   input level (already synchronised)
//   rdly   in   0->1 delay in cycles, sampled when a transition starts
//   fdly   in   1->0 delay in cycles, sampled when a transition starts
//   q      out  delayed, filtered level
//   pend   out  a transition is being timed
//   cancel out  1-cycle pulse after a pending transition was abandoned
// -----------------------------------------------------------------------------
module inertial_cell
   import edge_delay_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter logic        RST_Q = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          in,
   input  logic [DW-1:0] rdly,
   input  logic [DW-1:0] fdly,
   output logic          q,
   output logic          pend,
   output logic          cancel
);

   cell_state_t   state_q, state_d;
   logic          q_q, q_d;
   logic          tgt_q, tgt_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          cancel_q, cancel_d;

   // Narrow wrapper around the shared helper; the value always fits in DW
   // because it is either the input itself or 1.
   function automatic logic [DW-1:0] eff_dly(input logic [DW-1:0] d);
      return DW'(eff_delay(MAX_DW'(d)));
   endfunction

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_STABLE;
         q_q      <= RST_Q;
         tgt_q    <= RST_Q;
         cnt_q    <= '0;
         cancel_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         tgt_q    <= tgt_d;
         cnt_q    <= cnt_d;
         cancel_q <= cancel_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      tgt_d    = tgt_q;
      cnt_d    = cnt_q;
      cancel_d = 1'b0;

      if (en) begin
         unique case (state_q)
            ST_STABLE: begin
               if (in != q_q) begin
                  // Delay inputs are captured here only; later changes do
                  // not disturb a running count.
                  tgt_d   = in;
                  cnt_d   = in ? eff_dly(rdly) : eff_dly(fdly);
                  state_d = ST_PEND;
               end
            end
            ST_PEND: begin
               if (in == q_q) begin
                  // Input returned before expiry. Checked ahead of the
                  // counter so a return on the expiry edge still cancels.
                  state_d  = ST_STABLE;
                  cancel_d = 1'b1;
               end else if (cnt_q == DW'(1)) begin
                  q_d     = tgt_q;
                  state_d = ST_STABLE;
               end else begin
                  cnt_d = cnt_q - DW'(1);
               end
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign q      = q_q;
   assign pend   = (state_q == ST_PEND);
   // Masked by en so a frozen block never shows a cancellation pulse.
   assign cancel = cancel_q & en;

endmodule : inertial_cell

// File: rtl/edge_delay_filter.sv
// -----------------------------------------------------------------------------
// edge_delay_filter
//   CH independent channels, each shaping a data level and an output enable
//   with cycle-based rise / fall / turn-off delays and inertial rejection of
//   short pulses.
//
// Parameters
//   CH      : number of channels
//   DW      : width of delay values and per-channel counters
//   RST_VAL : reset level of every dout bit
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   global advance; 0 freezes all state
//   rise_dly  in   0->1 data delay (cycles), shared
//   fall_dly  in   1->0 data delay (cycles), shared
//   off_dly   in   oe 1->0 delay (cycles), shared
//   din       in   per-channel data input
//   oe_in     in   per-channel output-enable request
//   dout      out  delayed, filtered data
//   oe_out    out  delayed output enable (on after 1 cycle, off after off_dly)
//   busy      out  data path of the channel has a pending transition
//   glitch    out  1-cycle pulse: pending data transition cancelled
// -----------------------------------------------------------------------------
module edge_delay_filter
   import edge_delay_pkg::*;
#(
   parameter int unsigned CH      = 4,
   parameter int unsigned DW      = 8,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [DW-1:0] rise_dly,
   input  logic [DW-1:0] fall_dly,
   input  logic [DW-1:0] off_dly,
   input  logic [CH-1:0] din,
   input  logic [CH-1:0] oe_in,
   output logic [CH-1:0] dout,
   output logic [CH-1:0] oe_out,
   output logic [CH-1:0] busy,
   output logic [CH-1:0] glitch
);

   // The oe path turns on with a fixed single-cycle delay.
   localparam logic [DW-1:0] OE_ON_DLY = DW'(1);

   // Pending / cancel status of the oe cells is not reported externally.
   logic [CH-1:0] oe_pend_unused;
   logic [CH-1:0] oe_cancel_unused;

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch

      inertial_cell #(
         .DW    (DW),
         .RST_Q (RST_VAL)
      ) u_data (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (en),
         .in     (din[gi]),
         .rdly   (rise_dly),
         .fdly   (fall_dly),
         .q      (dout[gi]),
         .pend   (busy[gi]),
         .cancel (glitch[gi])
      );

      inertial_cell #(
         .DW    (DW),
         .RST_Q (1'b0)
      ) u_oe (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (en),
         .in     (oe_in[gi]),
         .rdly   (OE_ON_DLY),
         .fdly   (off_dly),
         .q      (oe_out[gi]),
         .pend   (oe_pend_unused[gi]),
         .cancel (oe_cancel_unused[gi])
      );

   end : g_ch

endmodule : edge_delay_filter
